// File: rtl/vga_scanout_if.sv
// Scan-out bus: raster position/strobes out, upstream colour and dither mode in,
// registered VGA pins out.
interface vga_scanout_if #(
   parameter int IN_BITS    = 6,
   parameter int OUT_BITS   = 2,
   parameter int FRAME_BITS = 11
);
   logic [1:0]            dither_mode;
   logic [10:0]           x;
   logic [9:0]            y;
   logic                  active;
   logic                  line_start;
   logic                  frame_start;
   logic [FRAME_BITS-1:0] frame;
   logic [IN_BITS-1:0]    r_in, g_in, b_in;
   logic                  hsync, vsync;
   logic [OUT_BITS-1:0]   r_out, g_out, b_out;

   modport master (
      input  dither_mode, r_in, g_in, b_in,
      output x, y, active, line_start, frame_start, frame,
             hsync, vsync, r_out, g_out, b_out
   );

   modport slave (
      output dither_mode, r_in, g_in, b_in,
      input  x, y, active, line_start, frame_start, frame,
             hsync, vsync, r_out, g_out, b_out
   );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out: raster counters, sync/blank generation, LEAD-cycle alignment
// with upstream colour, and per-channel ordered-dither reduction to the pins.

// One colour channel: truncate, or add a Bayer threshold and clamp.
module vga_dither_lane #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 2
) (
   input  logic                        dith_en,
   input  logic [IN_BITS-OUT_BITS-1:0] bd,
   input  logic [IN_BITS-1:0]          c,
   output logic [OUT_BITS-1:0]         q
);
   localparam int D = IN_BITS - OUT_BITS;
   localparam int W = IN_BITS + 2;
   localparam logic [W-1:0] MAXV = W'((1 << OUT_BITS) - 1);

   logic [W-1:0] v, vs;

   // c + c>>OUT_BITS stretches the code range before the threshold is added
   always_comb begin
      v  = W'(c) + W'(c >> OUT_BITS) + W'(bd);
      vs = v >> D;
      if (!dith_en)       q = c[IN_BITS-1 -: OUT_BITS];
      else if (vs > MAXV) q = MAXV[OUT_BITS-1:0];
      else                q = vs[OUT_BITS-1:0];
   end
endmodule

module vga_scanout #(
   parameter int   H_DISPLAY  = 1220,
   parameter int   H_FRONT    = 31,
   parameter int   H_SYNC     = 183,
   parameter int   H_BACK     = 91,
   parameter int   V_DISPLAY  = 480,
   parameter int   V_FRONT    = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BACK     = 33,
   parameter logic HSYNC_POL  = 1'b0,
   parameter logic VSYNC_POL  = 1'b0,
   parameter int   IN_BITS    = 6,
   parameter int   OUT_BITS   = 2,
   parameter int   LEAD       = 2,
   parameter int   FRAME_BITS = 11
) (
   input logic           clk48,
   input logic           rst,
   vga_scanout_if.master bus
);
   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int D         = IN_BITS - OUT_BITS;
   localparam int NUM_LANES = 3;

   localparam logic [10:0] X_LAST  = 11'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);
   localparam logic [10:0] X_DISP  = 11'(H_DISPLAY);
   localparam logic [10:0] X_HS0   = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] X_HS1   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0]  Y_DISP  = 10'(V_DISPLAY);
   localparam logic [9:0]  Y_VS0   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]  Y_VS1   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [2:0] xl;
      logic [1:0] yl;
      logic       f0;
   } tap_t;

   logic [10:0]           x_q;
   logic [9:0]            y_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [1:0]            mode_q;
   logic                  act, fs, ls;
   tap_t                  tap_now, tap_d;
   logic                  vld_d;

   // Raster position and frame count; wrap and frame increment share one edge
   always_ff @(posedge clk48) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         frame_q <= '0;
      end else if (x_q == X_LAST) begin
         x_q <= '0;
         if (y_q == Y_LAST) begin
            y_q     <= '0;
            frame_q <= frame_q + FRAME_BITS'(1);
         end else begin
            y_q <= y_q + 10'd1;
         end
      end else begin
         x_q <= x_q + 11'd1;
      end
   end

   // Strobes are held low during reset so the first post-reset cycle is the frame start
   always_comb begin
      act     = (x_q < X_DISP) && (y_q < Y_DISP);
      fs      = (x_q == 11'd0) && (y_q == 10'd0) && !rst;
      ls      = (x_q == X_DISP) && !rst;
      tap_now = '{hs: (x_q >= X_HS0) && (x_q < X_HS1),
                  vs: (y_q >= Y_VS0) && (y_q < Y_VS1),
                  xl: x_q[2:0], yl: y_q[1:0], f0: frame_q[0]};
   end

   // Dither mode only changes at the top of a frame
   always_ff @(posedge clk48) begin
      if (rst)     mode_q <= 2'd0;
      else if (fs) mode_q <= bus.dither_mode;
   end

   generate
      if (LEAD == 0) begin : g_nodly
         assign vld_d = act;
         assign tap_d = tap_now;
      end else begin : g_dly
         logic [LEAD-1:0] vld_pipe;
         tap_t            tap_pipe [LEAD];
         // Shift blank/sync/Bayer taps so they meet the colour sampled LEAD cycles later
         always_ff @(posedge clk48) begin
            if (rst) begin
               vld_pipe <= '0;
               for (int k = 0; k < LEAD; k++) tap_pipe[k] <= '0;
            end else begin
               vld_pipe[0] <= act;
               tap_pipe[0] <= tap_now;
               for (int k = 1; k < LEAD; k++) begin
                  vld_pipe[k] <= vld_pipe[k-1];
                  tap_pipe[k] <= tap_pipe[k-1];
               end
            end
         end
         assign vld_d = vld_pipe[LEAD-1];
         assign tap_d = tap_pipe[LEAD-1];
      end
   endgenerate

   logic [2:0]   bi, bx;
   logic [1:0]   bj;
   logic [4:0]   b5;
   logic [D-1:0] bd;
   logic         dith_en;

   // 8x4 Bayer threshold; temporal mode inverts x on odd frames
   always_comb begin
      bi      = tap_d.xl ^ {3{tap_d.f0 & mode_q[1]}};
      bj      = tap_d.yl;
      bx      = {bi[2], bi[1] ^ bj[1], bi[0] ^ bj[0]};
      b5      = {bx[0], bi[0], bx[1], bi[1], bx[2]};
      bd      = b5[4 -: D];
      dith_en = (mode_q != 2'd0);
   end

   logic [NUM_LANES-1:0][IN_BITS-1:0]  chan_in;
   logic [NUM_LANES-1:0][OUT_BITS-1:0] chan_q, chan_out;

   assign chan_in = {bus.r_in, bus.g_in, bus.b_in};

   generate
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         vga_dither_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
            .dith_en (dith_en),
            .bd      (bd),
            .c       (chan_in[l]),
            .q       (chan_q[l])
         );
      end
   endgenerate

   logic hsync_q, vsync_q;

   // Pin register: syncs and colour leave together, colour forced to 0 in blanking
   always_ff @(posedge clk48) begin
      if (rst) begin
         hsync_q  <= ~HSYNC_POL;
         vsync_q  <= ~VSYNC_POL;
         chan_out <= '0;
      end else begin
         hsync_q  <= tap_d.hs ? HSYNC_POL : ~HSYNC_POL;
         vsync_q  <= tap_d.vs ? VSYNC_POL : ~VSYNC_POL;
         chan_out <= vld_d ? chan_q : '0;
      end
   end

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.active      = act;
   assign bus.line_start  = ls;
   assign bus.frame_start = fs;
   assign bus.frame       = frame_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.r_out       = chan_out[2];
   assign bus.g_out       = chan_out[1];
   assign bus.b_out       = chan_out[0];
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 24x10 raster, LEAD=2.
module tb_vga_scanout;
   localparam int HT  = 24;   // 16 + 2 + 3 + 3
   localparam int VT  = 10;   // 6 + 1 + 2 + 1
   localparam int FT  = HT * VT;
   localparam int LD  = 2;
   localparam int LAT = LD + 1;

   logic clk48 = 1'b0;
   logic rst   = 1'b1;
   int   checks = 0, failures = 0, n = 0;
   int   fpat [0:15];
   int   fmode[0:15];
   int   sum_r = 0, sum_g = 0, sum_b = 0;

   vga_scanout_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(11)) vif ();

   vga_scanout #(
      .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .IN_BITS(6), .OUT_BITS(2), .LEAD(LD), .FRAME_BITS(11)
   ) dut (
      .clk48 (clk48),
      .rst   (rst),
      .bus   (vif)
   );

   always #5 clk48 = ~clk48;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk48);
      #1;
   endtask

   // 0: all black; 1: one lit pixel at (5,2); 2: dither test card, blanking driven bright
   function automatic int pat_val(int pat, int px, int py);
      if (pat == 0) return 0;
      if (pat == 1) return (px == 5 && py == 2) ? 63 : 0;
      if (!(px < 16 && py < 6)) return 63;
      if (py < 4) return (px < 8) ? 32 : 63;
      if (py == 4) return 0;
      return 47;
   endfunction

   function automatic int drive_val(int q);
      if (q < 0) return 0;
      return pat_val(fpat[q / FT], q % HT, (q / HT) % VT);
   endfunction

   // Expected pin colour for raster pixel index p; -1 where only the tile sum is checked
   function automatic int exp_col(int p);
      int px, py, fr, c, m;
      if (p < 0) return 0;
      px = p % HT; py = (p / HT) % VT; fr = p / FT;
      if (!(px < 16 && py < 6)) return 0;
      c = pat_val(fpat[fr], px, py);
      m = fmode[fr];
      if (c == 0)  return 0;
      if (c == 63) return 3;
      if (c == 47) return (m == 0) ? 2 : 3;
      if (m == 0)  return 2;
      if (px == 0 && py == 0) return (m >= 2 && (fr % 2) == 1) ? 3 : 2;
      return -1;
   endfunction

   task automatic run_cycles(input int pat, input logic [1:0] dm0, input int mid_at,
                             input logic [1:0] dm1, input int ncyc);
      int px, py, p, vpx, vpy, e, c;
      for (int k = 0; k < ncyc; k++) begin
         px = n % HT; py = (n / HT) % VT;
         chk("x", vif.x, px);
         chk("y", vif.y, py);
         chk("frame", vif.frame, (n / FT) % 2048);
         chk("active", vif.active, (px < 16 && py < 6));
         chk("line_start", vif.line_start, (px == 16));
         chk("frame_start", vif.frame_start, (px == 0 && py == 0));
         p   = n - LAT;
         vpx = (p < 0) ? -1 : p % HT;
         vpy = (p < 0) ? -1 : (p / HT) % VT;
         chk("hsync", vif.hsync, !(vpx >= 18 && vpx < 21));
         chk("vsync", vif.vsync, !(vpy >= 7 && vpy < 9));
         e = exp_col(p);
         if (e >= 0) begin
            chk("r_out", vif.r_out, e);
            chk("g_out", vif.g_out, e);
            chk("b_out", vif.b_out, e);
         end
         if (vpx == 0 && vpy == 0) begin
            sum_r = 0; sum_g = 0; sum_b = 0;
         end
         if (vpx >= 0 && vpx < 8 && vpy < 4) begin
            sum_r += int'(vif.r_out); sum_g += int'(vif.g_out); sum_b += int'(vif.b_out);
         end
         if (vpx == 0 && vpy == 5 && fpat[p / FT] == 2) begin
            chk("tile_sum_r", sum_r, (fmode[p / FT] == 0) ? 64 : 80);
            chk("tile_sum_g", sum_g, (fmode[p / FT] == 0) ? 64 : 80);
            chk("tile_sum_b", sum_b, (fmode[p / FT] == 0) ? 64 : 80);
         end
         if (k == 0) begin
            vif.dither_mode = dm0;
            fpat[n / FT]    = pat;
            fmode[n / FT]   = int'(dm0);
         end
         if (k == mid_at) vif.dither_mode = dm1;
         c = drive_val(n - LD);
         vif.r_in = 6'(c); vif.g_in = 6'(c); vif.b_in = 6'(c);
         tick();
         n++;
      end
   endtask

   initial begin
      // reset held with junk colour on the inputs
      vif.dither_mode = 2'd0;
      vif.r_in = 6'($urandom_range(0, 63));
      vif.g_in = 6'($urandom_range(0, 63));
      vif.b_in = 6'($urandom_range(0, 63));
      repeat (3) tick();
      chk("rst_hsync", vif.hsync, 1);
      chk("rst_vsync", vif.vsync, 1);
      chk("rst_r_out", vif.r_out, 0);
      chk("rst_g_out", vif.g_out, 0);
      chk("rst_b_out", vif.b_out, 0);
      chk("rst_x", vif.x, 0);
      chk("rst_y", vif.y, 0);
      chk("rst_frame", vif.frame, 0);
      chk("rst_frame_start", vif.frame_start, 0);
      chk("rst_line_start", vif.line_start, 0);
      rst = 1'b0;
      #1;
      chk("rel_frame_start", vif.frame_start, 1);

      // two blank frames: counters, strobes, sync placement
      run_cycles(0, 2'd0, -1, 2'd0, FT);
      run_cycles(0, 2'd0, -1, 2'd0, FT);
      // single lit pixel: colour latency
      run_cycles(1, 2'd0, -1, 2'd0, FT);
      // static Bayer, odd then even frame
      run_cycles(2, 2'd1, -1, 2'd0, FT);
      run_cycles(2, 2'd1, -1, 2'd0, FT);
      // truncate, with a mid-frame request for temporal mode
      run_cycles(2, 2'd0, 100, 2'd2, FT);
      // temporal Bayer even frame, then mode 3 odd frame
      run_cycles(2, 2'd2, -1, 2'd0, FT);
      run_cycles(2, 2'd3, -1, 2'd0, FT);
      // part of a frame, then reset mid-frame
      run_cycles(2, 2'd2, -1, 2'd0, 60);

      vif.r_in = 6'd63; vif.g_in = 6'd63; vif.b_in = 6'd63;
      vif.dither_mode = 2'd0;
      rst = 1'b1;
      tick();
      chk("mid_rst_x", vif.x, 0);
      chk("mid_rst_y", vif.y, 0);
      chk("mid_rst_frame", vif.frame, 0);
      chk("mid_rst_hsync", vif.hsync, 1);
      chk("mid_rst_r_out", vif.r_out, 0);
      chk("mid_rst_frame_start", vif.frame_start, 0);
      rst = 1'b0;
      #1;
      chk("mid_rel_frame_start", vif.frame_start, 1);
      for (int c = 0; c < 4; c++) begin
         chk("post_rst_r_out", vif.r_out, (c < 3) ? 0 : 3);
         chk("post_rst_b_out", vif.b_out, (c < 3) ? 0 : 3);
         chk("post_rst_hsync", vif.hsync, 1);
         if (c < 3) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
